entrada_tempo: RTL

ENTRADA_TEMPO -- requirements
Module: entrada_tempo

---
 rtl/entrada_tempo.sv | 80 ++++++++
 1 files changed

// File: rtl/entrada_tempo.sv
// entrada_tempo: debounced keypad entry of a 3-digit BCD cooking time with confirm/error pulses
module entrada_tempo #(
  parameter int DEB_CICLOS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  tecla,
  input  logic        tecla_valida,
  input  logic        porta,
  output logic [11:0] t,
  output logic        conf,
  output logic [1:0]  ndig,
  output logic        erro
);
  localparam logic [1:0] OCIOSO     = 2'd0;
  localparam logic [1:0] ENTRADA    = 2'd1;
  localparam logic [1:0] CONFIRMADO = 2'd2;

  logic [1:0] valida_s, porta_s, estado;
  logic [3:0] cnt;
  logic       armado, fim, aceita;

  assign fim    = cnt == 4'(DEB_CICLOS - 1);
  assign aceita = armado && valida_s[1] && fim;

  // two-flop synchronizers for the asynchronous key-held and door inputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valida_s <= '0;
      porta_s  <= '0;
    end else begin
      valida_s <= {valida_s[0], tecla_valida};
      porta_s  <= {porta_s[0], porta};
    end

  // counts consecutive press samples while armed, release samples while disarmed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      armado <= 1'b1;
      cnt    <= '0;
    end else if (armado == valida_s[1]) begin
      cnt <= fim ? '0 : cnt + 4'd1;
      if (fim) armado <= !armado;
    end else
      cnt <= '0;

  // key action on acceptance; conf and erro are single-cycle pulses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      estado <= OCIOSO;
      t      <= '0;
      ndig   <= '0;
      conf   <= 1'b0;
      erro   <= 1'b0;
    end else begin
      conf <= 1'b0;
      erro <= 1'b0;
      if (aceita) begin
        if (tecla <= 4'd9) begin
          if (estado == CONFIRMADO || ndig == 2'd3)
            erro <= 1'b1;
          else begin
            t      <= {t[7:0], tecla};
            ndig   <= ndig + 2'd1;
            estado <= ENTRADA;
          end
        end else if (tecla == 4'hA) begin
          t      <= '0;
          ndig   <= '0;
          estado <= OCIOSO;
        end else if (tecla == 4'hB) begin
          if (estado == ENTRADA && t != 12'h000 && !porta_s[1]) begin
            conf   <= 1'b1;
            estado <= CONFIRMADO;
          end else
            erro <= 1'b1;
        end
      end
    end
endmodule
